// File: rtl/ovc_alloc_ctrl_pkg.sv
// Shared FSM encoding and the LOG2 width helper for the output-VC allocator slice.
// LOG2 never returns 0, so a single-entry dimension still gets a one-bit field.
`ifndef OVC_ALLOC_CTRL_LOG2_DEFINED
`define OVC_ALLOC_CTRL_LOG2_DEFINED
`define LOG2(x) (((x) <= 1) ? 1 : $clog2(x))
`endif

package ovc_alloc_ctrl_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } alloc_state_e;

endpackage

// File: rtl/ovc_alloc_ctrl_if.sv
// Request/grant handshake between an input unit (master) and the output-VC allocator (slave).
interface ovc_alloc_if #(
  parameter int PORT_NUM        = 4,
  parameter int VC_NUM_PER_PORT = 4
);
  localparam int PORT_BCD_WIDTH = `LOG2(PORT_NUM);
  localparam int VC_BCD_WIDTH   = `LOG2(VC_NUM_PER_PORT);

  logic                      req_valid;
  logic [PORT_BCD_WIDTH-1:0] req_port;
  logic                      req_ready;
  logic                      gnt_valid;
  logic [PORT_BCD_WIDTH-1:0] gnt_port;
  logic [VC_BCD_WIDTH-1:0]   gnt_vc;

  modport master (
    output req_valid, req_port,
    input  req_ready, gnt_valid, gnt_port, gnt_vc
  );

  modport slave (
    input  req_valid, req_port,
    output req_ready, gnt_valid, gnt_port, gnt_vc
  );

endinterface

// File: rtl/ovc_alloc_ctrl_rr_arbiter.sv
// Pointer-based round-robin pick: the first set request bit found scanning upward
// from ptr, wrapping past the top index back to 0.
module rr_arbiter #(
  parameter int WIDTH     = 4,
  parameter int IDX_WIDTH = `LOG2(WIDTH)
) (
  input  logic [WIDTH-1:0]     req,
  input  logic [IDX_WIDTH-1:0] ptr,
  output logic                 gnt_any,
  output logic [IDX_WIDTH-1:0] gnt_idx
);

  int cand;

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    for (int i = 0; i < WIDTH; i++) begin
      cand = (int'(ptr) + i) % WIDTH;
      if (!gnt_any && req[IDX_WIDTH'(cand)]) begin
        gnt_any = 1'b1;
        gnt_idx = IDX_WIDTH'(cand);
      end
    end
  end

endmodule

// File: rtl/ovc_alloc_ctrl.sv
// Output-VC allocator: grants a free VC on the requested output port and tracks per-OVC credits.
// Define OVC_CREDIT_ERR_EN to add the sticky credit_err output for credit overflow/underflow.
module ovc_alloc_ctrl
  import ovc_alloc_ctrl_pkg::*;
#(
  parameter int PORT_NUM        = 4,
  parameter int VC_NUM_PER_PORT = 4,
  parameter int BUFF_DEPTH      = 4
) (
  input  logic                                    clk,
  input  logic                                    reset,
  ovc_alloc_if.slave                              alloc,
  input  logic [PORT_NUM*VC_NUM_PER_PORT-1:0]     flit_sent,
  input  logic [PORT_NUM*VC_NUM_PER_PORT-1:0]     tail_sent,
  input  logic [PORT_NUM*VC_NUM_PER_PORT-1:0]     credit_in,
  output logic [PORT_NUM*VC_NUM_PER_PORT-1:0]     ovc_allocated,
  output logic [PORT_NUM*VC_NUM_PER_PORT-1:0]     ovc_credit_avail
`ifdef OVC_CREDIT_ERR_EN
  ,
  output logic                                    credit_err
`endif
);

  localparam int PORT_BCD_WIDTH = `LOG2(PORT_NUM);
  localparam int VC_BCD_WIDTH   = `LOG2(VC_NUM_PER_PORT);
  localparam int CNT_WIDTH      = `LOG2(BUFF_DEPTH + 1);
  localparam int OVC_NUM        = PORT_NUM * VC_NUM_PER_PORT;

  localparam logic [CNT_WIDTH-1:0]    CNT_FULL = CNT_WIDTH'(BUFF_DEPTH);
  localparam logic [VC_BCD_WIDTH-1:0] VC_LAST  = VC_BCD_WIDTH'(VC_NUM_PER_PORT - 1);

  alloc_state_e              state;
  alloc_state_e              state_next;
  logic                      accept;
  logic [VC_BCD_WIDTH-1:0]   sel_vc;
  logic [OVC_NUM-1:0]        grant_onehot;
  logic [PORT_NUM-1:0]       port_free;
  logic [VC_BCD_WIDTH-1:0]   port_vc [PORT_NUM];
  logic [VC_BCD_WIDTH-1:0]   rr_ptr [PORT_NUM];
  logic [PORT_BCD_WIDTH-1:0] gnt_port_q;
  logic [VC_BCD_WIDTH-1:0]   gnt_vc_q;
  logic [CNT_WIDTH-1:0]      credit_cnt [OVC_NUM];
  logic [CNT_WIDTH-1:0]      credit_cnt_next [OVC_NUM];

  // Each port's arbiter looks only at that port's unallocated VCs.
  for (genvar p = 0; p < PORT_NUM; p++) begin : g_port_arb
    rr_arbiter #(
      .WIDTH     (VC_NUM_PER_PORT),
      .IDX_WIDTH (VC_BCD_WIDTH)
    ) u_rr_arbiter (
      .req     (~ovc_allocated[p*VC_NUM_PER_PORT +: VC_NUM_PER_PORT]),
      .ptr     (rr_ptr[p]),
      .gnt_any (port_free[p]),
      .gnt_idx (port_vc[p])
    );
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (alloc.req_valid && port_free[alloc.req_port]) begin
          accept     = 1'b1;
          state_next = ST_GRANT;
        end
      end
      ST_GRANT: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  assign sel_vc       = port_vc[alloc.req_port];
  assign grant_onehot = accept ? (OVC_NUM'(1) << (int'(alloc.req_port) * VC_NUM_PER_PORT + int'(sel_vc)))
                               : '0;

  assign alloc.req_ready = accept;
  assign alloc.gnt_valid = (state == ST_GRANT);
  assign alloc.gnt_port  = gnt_port_q;
  assign alloc.gnt_vc    = gnt_vc_q;

  // A tail release only becomes visible through the registered busy flags, so a VC
  // freed this cycle cannot be handed out until the next one.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      gnt_port_q    <= '0;
      gnt_vc_q      <= '0;
      ovc_allocated <= '0;
      for (int p = 0; p < PORT_NUM; p++) begin
        rr_ptr[p] <= '0;
      end
    end else begin
      state         <= state_next;
      gnt_port_q    <= accept ? alloc.req_port : '0;
      gnt_vc_q      <= accept ? sel_vc : '0;
      ovc_allocated <= (ovc_allocated & ~tail_sent) | grant_onehot;
      if (accept) begin
        rr_ptr[alloc.req_port] <= (sel_vc == VC_LAST) ? '0 : sel_vc + VC_BCD_WIDTH'(1);
      end
    end
  end

  // Flit and credit on the same OVC cancel; otherwise step the count, clamped to [0, BUFF_DEPTH].
  always_comb begin
    for (int i = 0; i < OVC_NUM; i++) begin
      credit_cnt_next[i] = credit_cnt[i];
      if (flit_sent[i] && !credit_in[i] && (credit_cnt[i] != '0)) begin
        credit_cnt_next[i] = credit_cnt[i] - CNT_WIDTH'(1);
      end else if (credit_in[i] && !flit_sent[i] && (credit_cnt[i] != CNT_FULL)) begin
        credit_cnt_next[i] = credit_cnt[i] + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < OVC_NUM; i++) begin
        credit_cnt[i] <= CNT_FULL;
      end
      ovc_credit_avail <= '1;
    end else begin
      for (int i = 0; i < OVC_NUM; i++) begin
        credit_cnt[i]       <= credit_cnt_next[i];
        ovc_credit_avail[i] <= (credit_cnt_next[i] != '0);
      end
    end
  end

`ifdef OVC_CREDIT_ERR_EN
  logic credit_fault;

  always_comb begin
    credit_fault = 1'b0;
    for (int i = 0; i < OVC_NUM; i++) begin
      if ((flit_sent[i] && !credit_in[i] && (credit_cnt[i] == '0)) ||
          (credit_in[i] && !flit_sent[i] && (credit_cnt[i] == CNT_FULL))) begin
        credit_fault = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      credit_err <= 1'b0;
    end else if (credit_fault) begin
      credit_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ovc_alloc_ctrl.sv
// Directed bench for ovc_alloc_ctrl: expected grants go into a queue that a separate
// monitor drains whenever gnt_valid is seen; credit and reset checks are direct.
module tb_ovc_alloc_ctrl;

  localparam int PORT_NUM   = 4;
  localparam int VC_NUM     = 4;
  localparam int BUFF_DEPTH = 4;
  localparam int OVC_NUM    = PORT_NUM * VC_NUM;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [OVC_NUM-1:0] flit_sent;
  logic [OVC_NUM-1:0] tail_sent;
  logic [OVC_NUM-1:0] credit_in;
  logic [OVC_NUM-1:0] ovc_allocated;
  logic [OVC_NUM-1:0] ovc_credit_avail;
`ifdef OVC_CREDIT_ERR_EN
  logic               credit_err;
`endif

  int compared   = 0;
  int mismatched = 0;
  int exp_q[$];
  int exp_ovc;
  bit monitor_on = 1'b0;

  ovc_alloc_if #(.PORT_NUM(PORT_NUM), .VC_NUM_PER_PORT(VC_NUM)) alloc_bus ();

  ovc_alloc_ctrl #(
    .PORT_NUM        (PORT_NUM),
    .VC_NUM_PER_PORT (VC_NUM),
    .BUFF_DEPTH      (BUFF_DEPTH)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .alloc            (alloc_bus),
    .flit_sent        (flit_sent),
    .tail_sent        (tail_sent),
    .credit_in        (credit_in),
    .ovc_allocated    (ovc_allocated),
    .ovc_credit_avail (ovc_credit_avail)
`ifdef OVC_CREDIT_ERR_EN
    ,
    .credit_err       (credit_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered and left just after a rising edge; an accepted request also consumes its grant cycle.
  task automatic applyStimulus(input int port, input logic [OVC_NUM-1:0] tail, input bit exp_ready, input int exp_vc);
    alloc_bus.req_valid = 1'b1;
    alloc_bus.req_port  = 2'(port);
    tail_sent           = tail;
    @(negedge clk);
    checkOutput($sformatf("req_ready_port%0d", port), 32'(alloc_bus.req_ready), 32'(exp_ready));
    if (exp_ready) exp_q.push_back(port * VC_NUM + exp_vc);
    tick();
    alloc_bus.req_valid = 1'b0;
    tail_sent           = '0;
    if (exp_ready) tick();
  endtask

  task automatic creditStep(input logic [OVC_NUM-1:0] flit, input logic [OVC_NUM-1:0] credit,
                            input int idx, input bit exp_avail);
    flit_sent = flit;
    credit_in = credit;
    tick();
    flit_sent = '0;
    credit_in = '0;
    @(negedge clk);
    checkOutput($sformatf("credit_avail%0d", idx), 32'(ovc_credit_avail[idx]), 32'(exp_avail));
    tick();
  endtask

  // Monitor: every grant must match the oldest queued expectation; idle cycles must show zero fields.
  initial begin
    wait (monitor_on);
    forever begin
      @(negedge clk);
      if (alloc_bus.gnt_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_grant", 32'(alloc_bus.gnt_valid), 32'd0);
        end else begin
          exp_ovc = exp_q.pop_front();
          checkOutput("gnt_port", 32'(alloc_bus.gnt_port), 32'(exp_ovc / VC_NUM));
          checkOutput("gnt_vc", 32'(alloc_bus.gnt_vc), 32'(exp_ovc % VC_NUM));
          checkOutput($sformatf("allocated%0d", exp_ovc), 32'(ovc_allocated[exp_ovc]), 32'd1);
        end
      end else begin
        checkOutput("idle_gnt_valid", 32'(alloc_bus.gnt_valid), 32'd0);
        checkOutput("idle_gnt_fields", 32'({alloc_bus.gnt_port, alloc_bus.gnt_vc}), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    alloc_bus.req_valid = 1'b0;
    alloc_bus.req_port  = '0;
    flit_sent           = '0;
    tail_sent           = '0;
    credit_in           = '0;
    repeat (2) tick();
    @(negedge clk);
    checkOutput("reset_gnt_valid", 32'(alloc_bus.gnt_valid), 32'd0);
    checkOutput("reset_gnt_fields", 32'({alloc_bus.gnt_port, alloc_bus.gnt_vc}), 32'd0);
    checkOutput("reset_allocated", 32'(ovc_allocated), 32'h0);
    checkOutput("reset_credit_avail", 32'(ovc_credit_avail), 32'hFFFF);
`ifdef OVC_CREDIT_ERR_EN
    checkOutput("reset_credit_err", 32'(credit_err), 32'd0);
`endif
    reset = 1'b0;
    monitor_on = 1'b1;
    tick();

    $display("[TB] single request to port 2");
    applyStimulus(2, '0, 1'b1, 0);

    $display("[TB] fill port 1, then block until a tail frees a VC");
    for (int v = 0; v < VC_NUM; v++) applyStimulus(1, '0, 1'b1, v);
    applyStimulus(1, '0, 1'b0, 0);
    applyStimulus(1, '0, 1'b0, 0);
    applyStimulus(1, OVC_NUM'(1) << 6, 1'b0, 0);
    applyStimulus(1, '0, 1'b1, 2);

    $display("[TB] release and request in the same cycle");
    applyStimulus(1, OVC_NUM'(1) << 5, 1'b0, 0);
    applyStimulus(1, '0, 1'b1, 1);

    $display("[TB] round-robin pointer order and wrap");
    applyStimulus(1, (OVC_NUM'(1) << 4) | (OVC_NUM'(1) << 7), 1'b0, 0);
    applyStimulus(1, '0, 1'b1, 3);
    applyStimulus(1, '0, 1'b1, 0);
    applyStimulus(3, '0, 1'b1, 0);
    applyStimulus(2, '0, 1'b1, 1);

    $display("[TB] credit overflow saturation on OVC 3");
    creditStep(OVC_NUM'(0), OVC_NUM'(1) << 3, 3, 1'b1);
`ifdef OVC_CREDIT_ERR_EN
    checkOutput("credit_err_overflow", 32'(credit_err), 32'd1);
`endif
    for (int k = 0; k < BUFF_DEPTH; k++) creditStep(OVC_NUM'(1) << 3, OVC_NUM'(0), 3, (k != BUFF_DEPTH - 1));

    $display("[TB] credit drain, cancel and underflow on OVC 0");
    for (int k = 0; k < BUFF_DEPTH; k++) creditStep(OVC_NUM'(1), OVC_NUM'(0), 0, (k != BUFF_DEPTH - 1));
    creditStep(OVC_NUM'(1), OVC_NUM'(1), 0, 1'b0);
    creditStep(OVC_NUM'(0), OVC_NUM'(1), 0, 1'b1);
    creditStep(OVC_NUM'(1), OVC_NUM'(1), 0, 1'b1);
    creditStep(OVC_NUM'(1), OVC_NUM'(0), 0, 1'b0);
    creditStep(OVC_NUM'(1), OVC_NUM'(0), 0, 1'b0);
    creditStep(OVC_NUM'(0), OVC_NUM'(1), 0, 1'b1);

    $display("[TB] reset overrides a same-cycle request");
    alloc_bus.req_valid = 1'b1;
    alloc_bus.req_port  = 2'd0;
    reset               = 1'b1;
    tick();
    alloc_bus.req_valid = 1'b0;
    reset               = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_allocated", 32'(ovc_allocated), 32'h0);
    checkOutput("post_reset_credit_avail", 32'(ovc_credit_avail), 32'hFFFF);
`ifdef OVC_CREDIT_ERR_EN
    checkOutput("post_reset_credit_err", 32'(credit_err), 32'd0);
`endif
    repeat (3) tick();
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ovc_alloc_ctrl.md
OVC_ALLOC_CTRL -- requirements
Module: ovc_alloc_ctrl

Interface
REQ-001 SHALL have parameter PORT_NUM, default 4, number of output ports.
REQ-002 SHALL have parameter VC_NUM_PER_PORT, default 4, VCs per output port.
REQ-003 SHALL have parameter BUFF_DEPTH, default 4, downstream flit slots (credits) per VC.
REQ-004 SHALL derive PORT_BCD_WIDTH = log2(PORT_NUM), VC_BCD_WIDTH = log2(VC_NUM_PER_PORT), CNT_WIDTH = log2(BUFF_DEPTH+1), OVC_NUM = PORT_NUM*VC_NUM_PER_PORT.
REQ-005 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port req_valid  in  1  VC allocation request.
REQ-008 SHALL have port req_port  in  PORT_BCD_WIDTH  binary output port requested.
REQ-009 SHALL have port req_ready  out  1  request accepted this cycle.
REQ-010 SHALL have port gnt_valid  out  1  one-cycle grant pulse.
REQ-011 SHALL have port gnt_port  out  PORT_BCD_WIDTH  granted port.
REQ-012 SHALL have port gnt_vc  out  VC_BCD_WIDTH  granted VC within port.
REQ-013 SHALL have port flit_sent  in  OVC_NUM  one-hot, flit forwarded on OVC (index port*VC_NUM_PER_PORT+vc).
REQ-014 SHALL have port tail_sent  in  OVC_NUM  tail flit forwarded; releases that OVC.
REQ-015 SHALL have port credit_in  in  OVC_NUM  credit returned per OVC, any number of bits per cycle.
REQ-016 SHALL have port ovc_allocated  out  OVC_NUM  registered busy flags, same packing as flit_sent (feeds the OVC status select mux).
REQ-017 SHALL have port ovc_credit_avail  out  OVC_NUM  registered flags, credit count nonzero.

Function
REQ-018 SHALL assert req_ready combinationally iff req_valid and port req_port has at least one VC with ovc_allocated=0 and gnt_valid is not pending that cycle.
REQ-019 SHALL select the free VC per port by round-robin starting at that port's pointer; pointer advances to granted VC+1, wrapping VC_NUM_PER_PORT-1 -> 0.
REQ-020 SHALL register the grant: gnt_valid, gnt_port, gnt_vc valid exactly one cycle after acceptance; ovc_allocated bit set in the same edge.
REQ-021 SHALL implement FSM IDLE -> GRANT (on accept) -> IDLE (unconditionally next cycle); at most one grant per two cycles.
REQ-022 SHALL clear ovc_allocated on tail_sent; a VC released in cycle N is allocatable no earlier than cycle N+1.
REQ-023 SHALL decrement the OVC credit counter on flit_sent, increment on credit_in; both in one cycle -> unchanged.
REQ-024 SHALL saturate counters at BUFF_DEPTH and at 0 (flit_sent at 0 credits is illegal; counter holds 0).
REQ-025 SHALL drive gnt_port/gnt_vc to 0 when gnt_valid=0.

Reset
REQ-026 SHALL on reset: FSM IDLE, gnt_valid=0, gnt_port=0, gnt_vc=0, ovc_allocated=0, all credit counters=BUFF_DEPTH, ovc_credit_avail=all ones, RR pointers=0.
REQ-027 SHALL let reset override all inputs in the same cycle, discarding any request accepted combinationally that cycle.

Configuration
REQ-028 SHALL support macro OVC_CREDIT_ERR_EN: when defined, adds output credit_err (1 bit, sticky until reset) set on any credit overflow above BUFF_DEPTH or flit_sent at 0 credits; when undefined, port absent and saturation is silent.

Structure
REQ-029 SHALL take log2 from the shared define file (LOG2 macro); FSM state encodings SHALL live in the shared package/define file.
REQ-030 SHALL instantiate one sub-module rr_arbiter (VC_NUM_PER_PORT-wide, pointer-based), one per port via generate.

Verification
REQ-031 SHALL test: reset, req_valid=1, req_port=2 -> cycle 1 gnt_valid=1, gnt_port=2, gnt_vc=0, ovc_allocated[8]=1.
REQ-032 SHALL test: four back-to-back requests to port 1 -> gnt_vc 0,1,2,3; fifth request -> req_ready=0 until tail_sent[4+k].
REQ-033 SHALL test: tail_sent[5] and req to port 1 same cycle, only VC1 free -> req_ready=0 that cycle, grant vc 1 next accepted.
REQ-034 SHALL test: 4 flit_sent[0] -> ovc_credit_avail[0]=0; flit_sent[0] and credit_in[0] same cycle -> counter unchanged.
REQ-035 SHALL test: with OVC_CREDIT_ERR_EN, 5th credit_in[3] at BUFF_DEPTH -> credit_err=1, counter stays 4; reset clears credit_err.
